// File: rtl/framing_pkg.sv
// Shared types and default sizing for the framing controller and its fill tracker.
package framing_pkg;

   // Default framing geometry: 256-sample Hanning window, 50% overlap, 2x zero padding.
   localparam int DEF_N         = 256;
   localparam int DEF_HOP       = 128;
   localparam int DEF_NF        = 512;
   localparam int DEF_BUF_DEPTH = 512;

   // Widths derived from the defaults (address, coefficient index, beat counter).
   localparam int DEF_AW = $clog2(DEF_BUF_DEPTH);
   localparam int DEF_CW = $clog2(DEF_N);
   localparam int DEF_KW = $clog2(DEF_NF);

   // Read-beat sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAD  = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/frame_fill_tracker.sv
// Write-side bookkeeping: circular RAM write pointer, fill/hop counting and
// generation of the frame-ready pulse together with the frame base address.
module frame_fill_tracker
   import framing_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int HOP       = DEF_HOP,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   localparam int AW       = $clog2(BUF_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          sample_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          frame_ready,
   output logic [AW-1:0] frame_base
);

   // Fill counter must be able to hold N itself (saturation value).
   localparam int FW = $clog2(N + 1);
   localparam int HW = $clog2(HOP + 1);

   localparam logic [FW-1:0] FILL_FULL = FW'(N);
   localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
   localparam logic [HW-1:0] HOP_LAST  = HW'(HOP - 1);
   localparam logic [AW-1:0] BASE_OFS  = AW'(N - 1);

   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [HW-1:0] hop_q, hop_d;

   assign wr_en      = sample_valid & enable;
   assign wr_addr    = wr_addr_q;
   assign wr_addr_d  = wr_en ? (wr_addr_q + AW'(1)) : wr_addr_q;
   // The sample being written now is the newest one of the frame.
   assign frame_base = wr_addr_q - BASE_OFS;

   // Fill/hop counting; a low enable restarts the fill from scratch.
   always_comb begin
      fill_d      = fill_q;
      hop_d       = hop_q;
      frame_ready = 1'b0;
      if (!enable) begin
         fill_d = '0;
         hop_d  = '0;
      end else if (wr_en) begin
         if (fill_q != FILL_FULL) begin
            fill_d      = fill_q + FW'(1);
            frame_ready = (fill_q == FILL_LAST);
         end else if (hop_q == HOP_LAST) begin
            hop_d       = '0;
            frame_ready = 1'b1;
         end else begin
            hop_d = hop_q + HW'(1);
         end
      end
   end

   // State registers for the write pointer and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q <= '0;
         fill_q    <= '0;
         hop_q     <= '0;
      end else begin
         wr_addr_q <= wr_addr_d;
         fill_q    <= fill_d;
         hop_q     <= hop_d;
      end
   end

endmodule

// File: rtl/frame_scheduler.sv
// Framing controller: turns frame-ready events into a stream of read beats
// (N data beats then NF-N pad beats) with one active and one pending frame.
module frame_scheduler
   import framing_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int HOP       = DEF_HOP,
   parameter int NF        = DEF_NF,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   localparam int AW       = $clog2(BUF_DEPTH),
   localparam int CW       = $clog2(N),
   localparam int KW       = $clog2(NF)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          sample_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [AW-1:0] rd_addr,
   output logic [CW-1:0] coeff_idx,
   output logic          pad,
   output logic          frame_start,
   output logic          frame_last,
   output logic [15:0]   frame_count,
   output logic          overrun,
   input  logic          clr_overrun,
   output logic          busy
);

   localparam logic [KW-1:0] K_LAST      = KW'(NF - 1);
   localparam logic [KW-1:0] K_LAST_DATA = KW'(N - 1);
   localparam logic [AW-1:0] LAST_OFS    = AW'(N - 1);

   fsm_state_t    state_q;
   logic [KW-1:0] k_q;
   logic [AW-1:0] base_q;
   logic          pend_valid_q;
   logic [AW-1:0] pend_base_q;
   logic          overrun_q;
   logic [15:0]   count_q;

   logic          frame_ready;
   logic [AW-1:0] frame_base;
   logic          accept;
   logic          eof;
   logic          active_free;
   logic          drop;

   frame_fill_tracker #(
      .N         (N),
      .HOP       (HOP),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fill (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .frame_ready  (frame_ready),
      .frame_base   (frame_base)
   );

   assign rd_valid    = (state_q != IDLE);
   assign accept      = rd_valid & rd_ready;
   assign eof         = accept & (k_q == K_LAST);
   // The active slot can take a new frame this cycle: idle, or last beat leaving.
   assign active_free = (state_q == IDLE) | eof;
   // A new frame with both slots occupied (and none leaving) is lost.
   assign drop        = frame_ready & pend_valid_q & ~active_free;

   assign frame_start = rd_valid & (k_q == '0);
   assign frame_last  = rd_valid & (k_q == K_LAST);
   assign pad         = (state_q == PAD);
   assign frame_count = count_q;
   assign overrun     = overrun_q;
   assign busy        = rd_valid | pend_valid_q;

   // Beat payload decode; pad beats repeat the last data address.
   always_comb begin
      rd_addr   = '0;
      coeff_idx = '0;
      case (state_q)
         DATA: begin
            rd_addr   = base_q + AW'(k_q);
            coeff_idx = k_q[CW-1:0];
         end
         PAD: begin
            rd_addr = base_q + LAST_OFS;
         end
         default: ;
      endcase
   end

   // Sequencer, pending slot, frame counter and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         k_q          <= '0;
         base_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_base_q  <= '0;
         overrun_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         if (active_free) begin
            k_q <= '0;
            if (pend_valid_q) begin
               // Pending frame goes first; a same-cycle arrival refills the slot.
               state_q      <= DATA;
               base_q       <= pend_base_q;
               pend_valid_q <= frame_ready;
               pend_base_q  <= frame_base;
            end else if (frame_ready) begin
               state_q <= DATA;
               base_q  <= frame_base;
            end else begin
               state_q <= IDLE;
            end
         end else begin
            if (accept) begin
               k_q <= k_q + KW'(1);
               if ((state_q == DATA) && (k_q == K_LAST_DATA)) begin
                  state_q <= PAD;
               end
            end
            if (frame_ready && !pend_valid_q) begin
               pend_valid_q <= 1'b1;
               pend_base_q  <= frame_base;
            end
         end

         if (eof) begin
            count_q <= count_q + 16'd1;
         end

         if (drop) begin
            overrun_q <= 1'b1;
         end else if (clr_overrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler with N=8, HOP=4, NF=16, BUF_DEPTH=16.
module tb_frame_scheduler;
   import framing_pkg::*;

   localparam int N   = 8;
   localparam int HOP = 4;
   localparam int NF  = 16;
   localparam int BD  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic        rd_ready = 1'b0;
   logic        clr_overrun = 1'b0;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic        rd_valid;
   logic [3:0]  rd_addr;
   logic [2:0]  coeff_idx;
   logic        pad;
   logic        frame_start;
   logic        frame_last;
   logic [15:0] frame_count;
   logic        overrun;
   logic        busy;

   frame_scheduler #(
      .N         (N),
      .HOP       (HOP),
      .NF        (NF),
      .BUF_DEPTH (BD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_addr      (rd_addr),
      .coeff_idx    (coeff_idx),
      .pad          (pad),
      .frame_start  (frame_start),
      .frame_last   (frame_last),
      .frame_count  (frame_count),
      .overrun      (overrun),
      .clr_overrun  (clr_overrun),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] addr;
      logic [2:0] coeff;
      logic       pad;
      logic       fs;
      logic       fl;
   } beat_t;

   beat_t exp_q[$];
   beat_t e;
   int    n_cmp = 0;
   int    n_bad = 0;

   // Model of the write side: address, fill, hop, frame index since reset.
   int m_wr = 0;
   int m_fill = 0;
   int m_hop = 0;
   int m_frames = 0;

   // Monitor statistics.
   int cyc = 0;
   int beats = 0;
   int first_cyc = -1;
   int last_cyc = -1;
   bit held = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_frame(input int base);
      for (int k = 0; k < NF; k++) begin
         beat_t b;
         b.addr  = (k < N) ? 4'((base + k) % BD) : 4'((base + N - 1) % BD);
         b.coeff = (k < N) ? 3'(k) : 3'd0;
         b.pad   = (k >= N);
         b.fs    = (k == 0);
         b.fl    = (k == NF - 1);
         exp_q.push_back(b);
      end
      $display("frame %0d queued: base=%0d", m_frames, base);
   endtask

   task automatic model_sample(input int drop_mask);
      bit fr;
      fr = 1'b0;
      if (!enable) return;
      if (m_fill < N) begin
         m_fill++;
         fr = (m_fill == N);
      end else begin
         m_hop++;
         if (m_hop == HOP) begin
            m_hop = 0;
            fr    = 1'b1;
         end
      end
      if (fr) begin
         if (drop_mask[m_frames] == 1'b0) push_frame((m_wr + BD - (N - 1)) % BD);
         else $display("frame %0d expected to be dropped", m_frames);
         m_frames++;
      end
      m_wr = (m_wr + 1) % BD;
   endtask

   task automatic set_enable(input bit v);
      enable = v;
      if (!v) begin
         m_fill = 0;
         m_hop  = 0;
      end
   endtask

   // One sample every 'gap' cycles; returns #1 after the edge that wrote the last one.
   task automatic drive_samples(input int n, input int gap, input int drop_mask, input bit clr_last);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         sample_valid = 1'b1;
         clr_overrun  = clr_last && (i == n - 1);
         model_sample(drop_mask);
         @(negedge clk);
         check("wr_en", wr_en, enable);
         for (int g = 1; g < gap; g++) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            clr_overrun  = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      clr_overrun  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      enable       = 1'b0;
      rd_ready     = 1'b0;
      clr_overrun  = 1'b0;
      exp_q.delete();
      m_wr     = 0;
      m_fill   = 0;
      m_hop    = 0;
      m_frames = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      check(tag, (c < budget), 1);
   endtask

   // Beat monitor: every valid beat must match the head of the expected queue.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) check("valid_held", rd_valid, 1);
         held = rd_valid && !rd_ready;
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", rd_valid, 0);
            end else begin
               e = exp_q[0];
               check("rd_addr", rd_addr, e.addr);
               check("coeff_idx", coeff_idx, e.coeff);
               check("pad", pad, e.pad);
               check("frame_start", frame_start, e.fs);
               check("frame_last", frame_last, e.fl);
               if (rd_ready) begin
                  void'(exp_q.pop_front());
                  beats++;
                  if (first_cyc < 0) first_cyc = cyc;
                  last_cyc = cyc;
                  if (e.fl) $display("beat accepted: frame end addr=%0d", rd_addr);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_count", frame_count, 0);
      do_reset();

      // Test 1: single frame, latency and pad beats
      set_enable(1'b1);
      rd_ready = 1'b1;
      drive_samples(7, 1, 0, 1'b0);
      check("t1_no_early_frame", rd_valid, 0);
      @(posedge clk);
      #1;
      sample_valid = 1'b1;
      model_sample(0);
      @(negedge clk);
      check("t1_valid_before", rd_valid, 0);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      check("t1_latency_valid", rd_valid, 1);
      check("t1_first_addr", rd_addr, 0);
      wait_drain("t1_drain", 100);
      check("t1_frame_count", frame_count, 1);
      check("t1_overrun", overrun, 0);

      // Test 2: continuous streaming, back-to-back frames with wrap
      do_reset();
      set_enable(1'b1);
      rd_ready  = 1'b1;
      beats     = 0;
      first_cyc = -1;
      drive_samples(24, 4, 0, 1'b0);
      wait_drain("t2_drain", 200);
      check("t2_frame_count", frame_count, 5);
      check("t2_beats", beats, 80);
      check("t2_no_bubble", last_cyc - first_cyc + 1, 80);
      check("t2_overrun", overrun, 0);

      // Test 3: rd_ready toggling mid-frame
      do_reset();
      set_enable(1'b1);
      rd_ready = 1'b1;
      beats    = 0;
      drive_samples(8, 1, 0, 1'b0);
      repeat (3) @(posedge clk);
      for (int c = 0; c < 200 && (exp_q.size() != 0 || busy); c++) begin
         #1;
         rd_ready = ~rd_ready;
         @(posedge clk);
      end
      #1;
      rd_ready = 1'b1;
      wait_drain("t3_drain", 50);
      check("t3_beats", beats, 16);
      check("t3_frame_count", frame_count, 1);

      // Test 4: downstream stalled, third and fourth frames dropped
      do_reset();
      set_enable(1'b1);
      rd_ready = 1'b0;
      drive_samples(16, 1, 'hC, 1'b0);
      check("t4_overrun_set", overrun, 1);
      check("t4_busy", busy, 1);
      drive_samples(4, 1, 'hC, 1'b1);
      check("t4_drop_beats_clr", overrun, 1);
      @(posedge clk);
      #1;
      clr_overrun = 1'b1;
      @(posedge clk);
      #1;
      clr_overrun = 1'b0;
      check("t4_overrun_cleared", overrun, 0);
      rd_ready = 1'b1;
      wait_drain("t4_drain", 200);
      check("t4_frame_count", frame_count, 2);

      // Test 5: reset during beat 5
      do_reset();
      set_enable(1'b1);
      rd_ready = 1'b1;
      drive_samples(8, 1, 0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", rd_valid, 0);
      check("t5_rst_addr", rd_addr, 0);
      check("t5_rst_fs", frame_start, 0);
      check("t5_rst_wr_addr", wr_addr, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_count", frame_count, 0);
      do_reset();
      set_enable(1'b1);
      rd_ready = 1'b1;
      drive_samples(7, 1, 0, 1'b0);
      check("t5_no_frame_yet", rd_valid, 0);
      drive_samples(1, 1, 0, 1'b0);
      check("t5_new_frame", rd_valid, 1);
      check("t5_base", rd_addr, 0);
      wait_drain("t5_drain", 100);
      check("t5_frame_count", frame_count, 1);

      // Test 6: enable dropped after 6 samples restarts the fill
      do_reset();
      set_enable(1'b1);
      rd_ready = 1'b1;
      drive_samples(6, 1, 0, 1'b0);
      set_enable(1'b0);
      drive_samples(3, 1, 0, 1'b0);
      check("t6_wr_addr_frozen", wr_addr, 6);
      set_enable(1'b1);
      drive_samples(7, 1, 0, 1'b0);
      check("t6_no_frame_yet", rd_valid, 0);
      drive_samples(1, 1, 0, 1'b0);
      check("t6_frame_valid", rd_valid, 1);
      check("t6_base", rd_addr, 6);
      wait_drain("t6_drain", 100);
      check("t6_frame_count", frame_count, 1);
      check("t6_overrun", overrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
